led_seq: RTL and testbench

Multi-channel LED sequencer: a successor to the single-output fixed-rate blinker. It drives `CHANNELS` independent LED outputs from one shared tick prescaler. Each channel is configured at run time through a one-cycle write port to one of four modes: off, on, blink at a programmable period, or blink-code (N flashes then a gap). It sits between a control register block or soft CPU and the board LED pins, and is used for status and error-code indication.

---
 rtl/led_seq.sv | 202 ++++++++++++++++++++
 tb/tb_led_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_seq.sv
// Multi-channel LED sequencer: a shared tick prescaler drives CHANNELS LEDs, each in OFF/ON/BLINK/CODE mode.
// Optional LED_SEQ_BREATHE_EN macro adds mode 4 (BREATHE, PWM duty ramp); undefined, mode 4 behaves as OFF.
module led_seq #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 12000,
  parameter int PER_W    = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [2:0]          wr_mode,
  input  logic [PER_W-1:0]    wr_period,
  input  logic [3:0]          wr_count,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = PER_W + 2;

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_ON      = 3'd1,
    M_BLINK   = 3'd2,
    M_CODE    = 3'd3,
    M_BREATHE = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON_PH  = 2'd1,
    OFF_PH = 2'd2,
    GAP    = 2'd3
  } phase_e;

  typedef struct packed {
    mode_e            mode;
    phase_e           phase;
    logic [PER_W-1:0] period;
    logic [3:0]       count;
    logic [TW-1:0]    tcnt;
    logic [3:0]       fcnt;
`ifdef LED_SEQ_BREATHE_EN
    logic [7:0]       duty;
    logic             dir_up;
`endif
  } ch_t;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  ch_t                 ch_q [CHANNELS];
  ch_t                 ch_d [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;
  logic [PER_W-1:0]    wr_per_sat;
`ifdef LED_SEQ_BREATHE_EN
  logic [7:0]          pwm_q, pwm_d;
`endif

  function automatic logic [TW-1:0] phase_reload(input logic [PER_W-1:0] p);
    return {2'b00, p} - TW'(1);
  endfunction

  // The gap lasts four phases, which is why tcnt carries two extra bits.
  function automatic logic [TW-1:0] gap_reload(input logic [PER_W-1:0] p);
    return {p, 2'b00} - TW'(1);
  endfunction

  assign wr_per_sat = (wr_period == '0) ? PER_W'(1) : wr_period;

  // NOTE: combinational blocks use blocking '=' and sequential blocks use '<='; mixing them causes sim/synth mismatch.
  always_comb begin
    tick_d  = (presc_q == '0);
    presc_d = tick_d ? PW'(TICK_DIV - 1) : presc_q - PW'(1);
`ifdef LED_SEQ_BREATHE_EN
    pwm_d   = pwm_q + 8'd1;
`endif
  end

  // Next-state: a write restarts its channel and wins over a coincident tick.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: default every comb output to its held value first so no path infers a latch.
      ch_d[i] = ch_q[i];
      if (wr_en && (int'(wr_ch) == i)) begin
        ch_d[i].period = wr_per_sat;
        ch_d[i].count  = wr_count;
        ch_d[i].fcnt   = wr_count;
        ch_d[i].tcnt   = phase_reload(wr_per_sat);
        ch_d[i].mode   = M_OFF;
        ch_d[i].phase  = IDLE;
        case (wr_mode)
          3'd1: ch_d[i].mode = M_ON;
          3'd2: begin
            ch_d[i].mode  = M_BLINK;
            ch_d[i].phase = ON_PH;
          end
          3'd3: begin
            if (wr_count != 4'd0) begin
              ch_d[i].mode  = M_CODE;
              ch_d[i].phase = ON_PH;
            end
          end
`ifdef LED_SEQ_BREATHE_EN
          3'd4: begin
            ch_d[i].mode   = M_BREATHE;
            ch_d[i].duty   = 8'd0;
            ch_d[i].dir_up = 1'b1;
          end
`endif
          default: ;
        endcase
      end else if (tick_q) begin
        case (ch_q[i].mode)
          M_BLINK, M_CODE: begin
            if (ch_q[i].tcnt != '0) begin
              ch_d[i].tcnt = ch_q[i].tcnt - TW'(1);
            end else begin
              ch_d[i].tcnt = phase_reload(ch_q[i].period);
              case (ch_q[i].phase)
                ON_PH: ch_d[i].phase = OFF_PH;
                OFF_PH: begin
                  ch_d[i].phase = ON_PH;
                  if (ch_q[i].mode == M_CODE) begin
                    ch_d[i].fcnt = ch_q[i].fcnt - 4'd1;
                    if (ch_q[i].fcnt == 4'd1) begin
                      ch_d[i].phase = GAP;
                      ch_d[i].tcnt  = gap_reload(ch_q[i].period);
                    end
                  end
                end
                GAP: begin
                  ch_d[i].phase = ON_PH;
                  ch_d[i].fcnt  = ch_q[i].count;
                end
                default: ;
              endcase
            end
          end
`ifdef LED_SEQ_BREATHE_EN
          M_BREATHE: begin
            if (ch_q[i].tcnt != '0) begin
              ch_d[i].tcnt = ch_q[i].tcnt - TW'(1);
            end else begin
              ch_d[i].tcnt = phase_reload(ch_q[i].period);
              if (ch_q[i].dir_up) begin
                ch_d[i].duty = ch_q[i].duty + 8'd1;
                if (ch_q[i].duty == 8'd254) ch_d[i].dir_up = 1'b0;
              end else begin
                ch_d[i].duty = ch_q[i].duty - 8'd1;
                if (ch_q[i].duty == 8'd1) ch_d[i].dir_up = 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // LED drive is decoded from the next state so a write shows up one cycle later.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (ch_d[i].mode)
        M_ON:            led_d[i] = 1'b1;
        M_BLINK, M_CODE: led_d[i] = (ch_d[i].phase == ON_PH);
`ifdef LED_SEQ_BREATHE_EN
        M_BREATHE:       led_d[i] = (pwm_q < ch_d[i].duty);
`endif
        default:         led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= PW'(TICK_DIV - 1);
      tick_q  <= 1'b0;
      led_q   <= '0;
      // NOTE: per-channel state is a handful of flops, not a RAM, so resetting every entry is cheap and required.
      for (int i = 0; i < CHANNELS; i++) ch_q[i] <= '0;
`ifdef LED_SEQ_BREATHE_EN
      pwm_q   <= 8'd0;
`endif
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      for (int i = 0; i < CHANNELS; i++) ch_q[i] <= ch_d[i];
`ifdef LED_SEQ_BREATHE_EN
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_seq.sv
// Bench for led_seq: hand-derived vector table, corner sequences, then random writes against a tick-count model.
module tb_led_seq;

  localparam int NCH = 5;
  localparam int TD  = 4;
  localparam int PW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_ch = '0;
  logic [2:0]     wr_mode = '0;
  logic [PW-1:0]  wr_period = '0;
  logic [3:0]     wr_count = '0;
  logic           tick;
  logic [NCH-1:0] led;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: per channel, the configuration and the number of ticks seen since its last write.
  int m_mode [NCH];
  int m_per  [NCH];
  int m_cnt  [NCH];
  int m_n    [NCH];
  int cyc = 0;

  typedef struct {
    logic           we;
    logic [2:0]     ch;
    logic [2:0]     mode;
    logic [PW-1:0]  per;
    logic [3:0]     cnt;
    int             cycles;
    logic [NCH-1:0] exp_led;
    logic           exp_tick;
  } vec_t;

  vec_t vecs [22];

  led_seq #(.CHANNELS(NCH), .TICK_DIV(TD), .PER_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_mode   (wr_mode),
    .wr_period (wr_period),
    .wr_count  (wr_count),
    .tick      (tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  function automatic logic model_tick();
    return (cyc > 0) && (cyc % TD == 0);
  endfunction

  function automatic logic model_led(input int c);
    int p, k, n, len, m;
    p = m_per[c];
    k = m_cnt[c];
    n = m_n[c];
    case (m_mode[c])
      1: return 1'b1;
      2: return ((n / p) % 2) == 0;
      3: begin
        if (k == 0) return 1'b0;
        len = 2 * k * p + 4 * p;
        m   = n % len;
        return (m < 2 * k * p) && (((m / p) % 2) == 0);
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NCH-1:0] model_leds();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c] = model_led(c);
    return v;
  endfunction

  task automatic model_step();
    logic t;
    if (rst) begin
      cyc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_per[c] = 1; m_cnt[c] = 0; m_n[c] = 0;
      end
    end else begin
      t = model_tick();
      for (int c = 0; c < NCH; c++) begin
        if (wr_en && int'(wr_ch) == c) begin
          m_mode[c] = int'(wr_mode);
          m_per[c]  = (wr_period == 0) ? 1 : int'(wr_period);
          m_cnt[c]  = int'(wr_count);
          m_n[c]    = 0;
        end else if (t) begin
          m_n[c]++;
        end
      end
      cyc++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic write(input int ch, input int mode, input int per, input int cnt);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_mode = 3'(mode); wr_period = PW'(per); wr_count = 4'(cnt);
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    // {we, ch, mode, period, count, cycles, led after last cycle, tick after last cycle}
    vecs[0]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 1,  5'b00000, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 3,  5'b00000, 1'b1};
    vecs[2]  = '{1'b1, 3'd0, 3'd2, 8'd3, 4'd0, 1,  5'b00001, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 11, 5'b00001, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 1,  5'b00000, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 11, 5'b00000, 1'b1};
    vecs[6]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 1,  5'b00001, 1'b0};
    vecs[7]  = '{1'b1, 3'd1, 3'd3, 8'd1, 4'd2, 1,  5'b00011, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 3,  5'b00001, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 4,  5'b00011, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 4,  5'b00000, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 4,  5'b00000, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 12, 5'b00001, 1'b0};
    vecs[13] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 4,  5'b00011, 1'b0};
    vecs[14] = '{1'b1, 3'd5, 3'd1, 8'd1, 4'd0, 1,  5'b00011, 1'b0};
    vecs[15] = '{1'b1, 3'd3, 3'd3, 8'd2, 4'd0, 1,  5'b00011, 1'b0};
    vecs[16] = '{1'b1, 3'd2, 3'd2, 8'd0, 4'd0, 1,  5'b00111, 1'b1};
    vecs[17] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 1,  5'b00000, 1'b0};
    vecs[18] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 4,  5'b00110, 1'b0};
    vecs[19] = '{1'b1, 3'd0, 3'd2, 8'd2, 4'd0, 1,  5'b00111, 1'b0};
    vecs[20] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 6,  5'b00001, 1'b1};
    vecs[21] = '{1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 1,  5'b00100, 1'b0};

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("reset%0d_led", i), 32'(led), 32'd0);
      check($sformatf("reset%0d_tick", i), 32'(tick), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      wr_en = vecs[i].we; wr_ch = vecs[i].ch; wr_mode = vecs[i].mode;
      wr_period = vecs[i].per; wr_count = vecs[i].cnt;
      cycle();
      wr_en = 1'b0;
      for (int j = 1; j < vecs[i].cycles; j++) cycle();
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
    end

    // Reset in the middle of a CODE sequence clears everything and channels stay off.
    rst = 1'b1;
    cycle();
    check("midreset_led", 32'(led), 32'd0);
    check("midreset_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check($sformatf("post_reset%0d_led", i), 32'(led), 32'd0);
    end

    // Mode 4 without the breathe option, and modes 5..7, drive the LED low.
    write(4, 4, 1, 0);
    check("mode4_off", 32'(led), 32'd0);
    write(4, 1, 1, 0);
    check("mode1_on", 32'(led), 32'h10);
    write(4, 7, 1, 0);
    check("mode7_off", 32'(led), 32'd0);
    write(4, 1, 1, 0);
    write(4, 5, 3, 2);
    check("mode5_off", 32'(led), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      wr_en = ($urandom_range(0, 7) == 0);
      wr_ch = 3'($urandom_range(0, 7));
      wr_mode = 3'($urandom_range(0, 7));
      wr_period = PW'($urandom_range(0, 5));
      wr_count = 4'($urandom_range(0, 3));
      cycle();
      check($sformatf("rand%0d_led", i), 32'(led), 32'(model_leds()));
      check($sformatf("rand%0d_tick", i), 32'(tick), 32'(model_tick()));
    end
    rst = 1'b0;
    wr_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
